// File: rtl/wb_arb.sv
// Writeback arbiter: merges NCH execution pipes onto one register-file write port,
// retiring no-writeback instructions in parallel and reporting a per-cycle retire count.
module wb_arb #(
  parameter int unsigned NCH    = 3,
  parameter int unsigned XLEN   = 64,
  parameter bit          RR     = 1'b1,
  parameter int unsigned STARVE = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NCH-1:0]              ch_valid,
  input  logic [NCH-1:0]              ch_wb_en,
  input  logic [NCH*5-1:0]            ch_dst,
  input  logic [NCH*XLEN-1:0]         ch_result,
  output logic [NCH-1:0]              ch_ready,
  output logic                        rf_wen,
  output logic [4:0]                  rf_wdst,
  output logic [XLEN-1:0]             rf_wdata,
  output logic [$clog2(NCH+1)-1:0]    retire_cnt
);

  localparam int unsigned PtrW = $clog2(NCH);
  localparam int unsigned CntW = $clog2(NCH+1);

  logic [NCH-1:0] req, rwowb, grant, acc;

  always_comb begin
    req   = '0;
    rwowb = '0;
    for (int i = 0; i < NCH; i++) begin
      req[i]   = ch_valid[i] & ch_wb_en[i] & (ch_dst[5*i +: 5] != 5'd0);
      rwowb[i] = ch_valid[i] & ~req[i];
    end
    ch_ready = ~ch_valid | rwowb | grant;
    acc      = ch_valid & ch_ready;
  end

  if (RR) begin : g_rr
    logic [PtrW-1:0] ptr_q, ptr_d;

    // Two passes: channels at or above the pointer first, then the wrapped-around ones.
    always_comb begin
      grant = '0;
      ptr_d = ptr_q;
      for (int i = 0; i < NCH; i++) begin
        if (grant == '0 && req[i] && PtrW'(i) >= ptr_q) grant[i] = 1'b1;
      end
      for (int i = 0; i < NCH; i++) begin
        if (grant == '0 && req[i]) grant[i] = 1'b1;
      end
      for (int i = 0; i < NCH; i++) begin
        if (grant[i]) ptr_d = (i == NCH - 1) ? '0 : PtrW'(i + 1);
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) ptr_q <= '0;
      else      ptr_q <= ptr_d;
    end
  end else begin : g_fixed
    logic [3:0] wcnt_q [NCH];
    logic [3:0] wcnt_d [NCH];

    always_comb begin
      grant = '0;
      if (STARVE != 0) begin
        for (int i = 0; i < NCH; i++) begin
          if (grant == '0 && req[i] && wcnt_q[i] >= 4'(STARVE)) grant[i] = 1'b1;
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (grant == '0 && req[i]) grant[i] = 1'b1;
      end
      for (int i = 0; i < NCH; i++) begin
        if (req[i] && !grant[i]) wcnt_d[i] = (wcnt_q[i] == 4'hf) ? 4'hf : wcnt_q[i] + 4'd1;
        else                     wcnt_d[i] = 4'd0;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < NCH; i++) wcnt_q[i] <= 4'd0;
      end else begin
        for (int i = 0; i < NCH; i++) wcnt_q[i] <= wcnt_d[i];
      end
    end
  end

  logic            rf_wen_q, rf_wen_d;
  logic [4:0]      rf_wdst_q, rf_wdst_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic [CntW-1:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    rf_wen_d     = |grant;
    rf_wdst_d    = rf_wdst_q;
    rf_wdata_d   = rf_wdata_q;
    retire_cnt_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        rf_wdst_d  = ch_dst[5*i +: 5];
        rf_wdata_d = ch_result[XLEN*i +: XLEN];
      end
      retire_cnt_d = retire_cnt_d + CntW'(acc[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_wen_q     <= 1'b0;
      rf_wdst_q    <= '0;
      rf_wdata_q   <= '0;
      retire_cnt_q <= '0;
    end else begin
      rf_wen_q     <= rf_wen_d;
      rf_wdst_q    <= rf_wdst_d;
      rf_wdata_q   <= rf_wdata_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign rf_wen     = rf_wen_q;
  assign rf_wdst    = rf_wdst_q;
  assign rf_wdata   = rf_wdata_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_arb.sv
// Scoreboard bench for wb_arb: one round-robin instance and two fixed-priority instances
// (STARVE = 4 and STARVE = 0) share the channel inputs.
module tb_wb_arb;
  localparam int NCH  = 3;
  localparam int XLEN = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NCH-1:0]      ch_valid, ch_wb_en;
  logic [NCH*5-1:0]    ch_dst;
  logic [NCH*XLEN-1:0] ch_result;

  logic [NCH-1:0] rr_ready, f4_ready, f0_ready;
  logic           rr_wen, f4_wen, f0_wen;
  logic [4:0]     rr_wdst, f4_wdst, f0_wdst;
  logic [63:0]    rr_wdata, f4_wdata, f0_wdata;
  logic [1:0]     rr_cnt, f4_cnt, f0_cnt;

  wb_arb #(.NCH(NCH), .XLEN(XLEN), .RR(1'b1), .STARVE(4)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_wb_en(ch_wb_en), .ch_dst(ch_dst),
    .ch_result(ch_result), .ch_ready(rr_ready), .rf_wen(rr_wen), .rf_wdst(rr_wdst),
    .rf_wdata(rr_wdata), .retire_cnt(rr_cnt));

  wb_arb #(.NCH(NCH), .XLEN(XLEN), .RR(1'b0), .STARVE(4)) dut_f4 (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_wb_en(ch_wb_en), .ch_dst(ch_dst),
    .ch_result(ch_result), .ch_ready(f4_ready), .rf_wen(f4_wen), .rf_wdst(f4_wdst),
    .rf_wdata(f4_wdata), .retire_cnt(f4_cnt));

  wb_arb #(.NCH(NCH), .XLEN(XLEN), .RR(1'b0), .STARVE(0)) dut_f0 (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_wb_en(ch_wb_en), .ch_dst(ch_dst),
    .ch_result(ch_result), .ch_ready(f0_ready), .rf_wen(f0_wen), .rf_wdst(f0_wdst),
    .rf_wdata(f0_wdata), .retire_cnt(f0_cnt));

  typedef struct packed {
    logic [4:0]  dst;
    logic [63:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  bit  mon_sel = 1'b0;   // 0: round-robin instance, 1: fixed STARVE=4 instance
  bit  mon_stop = 1'b0;

  logic [NCH-1:0] sel_ready;
  logic           sel_wen;
  logic [4:0]     sel_wdst;
  logic [63:0]    sel_wdata;
  logic [1:0]     sel_cnt;

  always_comb begin
    sel_ready = mon_sel ? f4_ready : rr_ready;
    sel_wen   = mon_sel ? f4_wen   : rr_wen;
    sel_wdst  = mon_sel ? f4_wdst  : rr_wdst;
    sel_wdata = mon_sel ? f4_wdata : rr_wdata;
    sel_cnt   = mon_sel ? f4_cnt   : rr_cnt;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_ch(input int i, input bit v, input bit wb, input logic [4:0] d,
                        input logic [63:0] r);
    ch_valid[i]              = v;
    ch_wb_en[i]              = wb;
    ch_dst[5*i +: 5]         = d;
    ch_result[XLEN*i +: XLEN] = r;
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic step(input string name, input logic [2:0] exp_ready, input bit push,
                      input logic [4:0] d, input logic [63:0] r);
    logic [2:0] acc;
    wr_t        w;
    #1;
    chk({name, " ready"}, 64'(sel_ready), 64'(exp_ready));
    acc = ch_valid & exp_ready;
    if (push) begin
      w.dst  = d;
      w.data = r;
      exp_q.push_back(w);
    end
    @(posedge clk);
    #1;
    chk({name, " retire"}, 64'(sel_cnt), 64'($countones(acc)));
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (!mon_stop && rst === 1'b1 && sel_wen === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got dst %0d data %0h expected none", sel_wdst,
                   sel_wdata);
        end else begin
          w = exp_q.pop_front();
          chk("wr_dst", 64'(sel_wdst), 64'(w.dst));
          chk("wr_data", sel_wdata, w.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] f_ready [6];
    int         n0;
    wr_t        dummy;

    // Reset held with all channels requesting.
    rst = 1'b0;
    for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 1'b1, 5'(i + 1), 64'(i + 100));
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wen", 64'(rr_wen), 64'd0);
    chk("rst_cnt", 64'(rr_cnt), 64'd0);
    for (int i = 0; i < NCH; i++) set_ch(i, 1'b0, 1'b0, 5'd0, 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_wen", 64'(rr_wen), 64'd0);
    chk("idle_cnt", 64'(rr_cnt), 64'd0);
    chk("idle_wdst", 64'(rr_wdst), 64'd0);
    chk("idle_wdata", rr_wdata, 64'd0);

    // Round-robin rotation with all three channels requesting.
    set_ch(0, 1'b1, 1'b1, 5'd1, 64'h1111);
    set_ch(1, 1'b1, 1'b1, 5'd2, 64'h2222);
    set_ch(2, 1'b1, 1'b1, 5'd3, 64'h3333);
    step("rr0", 3'b001, 1'b1, 5'd1, 64'h1111);
    step("rr1", 3'b010, 1'b1, 5'd2, 64'h2222);
    step("rr2", 3'b100, 1'b1, 5'd3, 64'h3333);
    step("rr3", 3'b001, 1'b1, 5'd1, 64'h1111);

    // Mixed: no-wb retire, x0 write, real write all accepted together (ptr = 1).
    set_ch(0, 1'b1, 1'b0, 5'd4, 64'h4444);
    set_ch(1, 1'b1, 1'b1, 5'd0, 64'h5555);
    set_ch(2, 1'b1, 1'b1, 5'd5, 64'hDEADBEEF);
    step("mixed", 3'b111, 1'b1, 5'd5, 64'hDEADBEEF);

    // Stall hold on ch1 (ptr = 0 here).
    set_ch(0, 1'b0, 1'b0, 5'd0, 64'd0);
    set_ch(1, 1'b1, 1'b1, 5'd7, 64'hA1);
    set_ch(2, 1'b0, 1'b0, 5'd0, 64'd0);
    step("st1", 3'b111, 1'b1, 5'd7, 64'hA1);
    set_ch(0, 1'b1, 1'b1, 5'd8, 64'hB0);
    set_ch(1, 1'b1, 1'b1, 5'd9, 64'hC0FFEE);
    set_ch(2, 1'b1, 1'b1, 5'd10, 64'hB2);
    step("st2", 3'b100, 1'b1, 5'd10, 64'hB2);
    set_ch(2, 1'b1, 1'b1, 5'd11, 64'hC2);
    step("st3", 3'b001, 1'b1, 5'd8, 64'hB0);
    set_ch(0, 1'b1, 1'b1, 5'd12, 64'hC0);
    step("st4", 3'b010, 1'b1, 5'd9, 64'hC0FFEE);
    set_ch(1, 1'b1, 1'b1, 5'd13, 64'hD1);
    step("st5", 3'b100, 1'b1, 5'd11, 64'hC2);
    for (int i = 0; i < NCH; i++) set_ch(i, 1'b0, 1'b0, 5'd0, 64'd0);
    step("drain", 3'b111, 1'b0, 5'd0, 64'd0);

    // Asynchronous reset while a write sits in the output register.
    set_ch(0, 1'b1, 1'b1, 5'd3, 64'h55);
    @(posedge clk);
    #1;
    set_ch(0, 1'b0, 1'b0, 5'd0, 64'd0);
    chk("pre_rst_wen", 64'(rr_wen), 64'd1);
    rst = 1'b0;
    #1;
    chk("async_wen", 64'(rr_wen), 64'd0);
    chk("async_wdst", 64'(rr_wdst), 64'd0);
    chk("async_wdata", rr_wdata, 64'd0);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Fixed priority starvation: ch0 keeps requesting, ch2 must win on the 5th cycle.
    mon_sel = 1'b1;
    f_ready = '{3'b011, 3'b011, 3'b011, 3'b011, 3'b110, 3'b011};
    n0 = 0;
    set_ch(2, 1'b1, 1'b1, 5'd2, 64'hE0);
    for (int c = 0; c < 6; c++) begin
      set_ch(0, 1'b1, 1'b1, 5'd1, 64'hF0 + 64'(n0));
      #1;
      chk("f0_ready", 64'(f0_ready), 64'(3'b011));
      if (c == 4) step("fix_starve", f_ready[c], 1'b1, 5'd2, 64'hE0);
      else        step("fix", f_ready[c], 1'b1, 5'd1, 64'hF0 + 64'(n0));
      if (f_ready[c][0]) n0++;
      if (f_ready[c][2]) set_ch(2, 1'b1, 1'b1, 5'd2, 64'hE1);
    end
    for (int i = 0; i < NCH; i++) set_ch(i, 1'b0, 1'b0, 5'd0, 64'd0);
    step("fix_drain", 3'b111, 1'b0, 5'd0, 64'd0);

    mon_stop = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      dummy = exp_q[0];
      $display("FAIL missing_writes: got %0d pending (first dst %0d) expected 0", exp_q.size(),
               dummy.dst);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
